// File: rtl/rr_arb8_sel_pkg.sv
// arb_pkg: shared constants, FSM state type and one-hot helper for the 8-way round-robin arbiter
package arb_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic logic [N_CH-1:0] onehot8(input logic [SEL_W-1:0] s);
    return {{(N_CH-1){1'b0}}, 1'b1} << s;
  endfunction
endpackage

// File: rtl/rr_arb8_sel_pick8.sv
// rr_pick8: combinational rotating priority search, first set request at or after base (mod 8)
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;
  // rotate so base lands at bit 0, then take the lowest set bit as the offset from base
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N_CH; i++) rot[i] = req[SEL_W'(i) + base];
    for (int i = N_CH - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
  end
  assign found = |req;
  assign idx   = base + off;
endmodule

// File: rtl/rr_arb8_sel.sv
// rr_arb8_sel: round-robin grant select for an 8:1 mux; RR_ARB_LOCK_EN adds a lock input to hold bursts
module rr_arb8_sel
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             gnt_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic             gnt_valid,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gnt_onehot
);
  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, base;
  logic             found, lk, accept;
  logic [SEL_W-1:0] idx;
`ifdef RR_ARB_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif
  assign accept = state_q == GRANT && gnt_ready;
  assign base   = state_q == IDLE ? ptr_q : sel_q + 3'd1;
  rr_pick8 u_pick (.req(req), .base(base), .found(found), .idx(idx));
  // searching from sel+1 reaches the just-served channel last, so it is only re-granted when alone
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    if (state_q == IDLE && found) begin
      state_d = GRANT;
      sel_d   = idx;
    end else if (accept && !lk) begin
      ptr_d   = sel_q + 3'd1;
      sel_d   = found ? idx : sel_q;
      state_d = found ? GRANT : IDLE;
    end
  end
  // state, priority pointer and registered select
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end
  assign gnt_valid  = state_q == GRANT;
  assign sel        = sel_q;
  assign gnt_onehot = gnt_valid ? onehot8(sel_q) : '0;
endmodule

// File: tb/tb_rr_arb8_sel.sv
// tb_rr_arb8_sel: directed self-checking bench for rr_arb8_sel with an 8:1 mux scoreboard
module tb_rr_arb8_sel;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] req = 0;
  logic       gnt_ready = 0;
  logic       lock = 0;
  logic       gnt_valid;
  logic [2:0] sel;
  logic [7:0] gnt_onehot;
  logic [7:0] din [8];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arb8_sel dut (
    .clk(clk), .rst(rst), .req(req), .gnt_ready(gnt_ready),
`ifdef RR_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt_valid(gnt_valid), .sel(sel), .gnt_onehot(gnt_onehot)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0; gnt_ready = 0; lock = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 8'hFF; gnt_ready = 1;
    step(); step(); step();
    checks++;
    if (gnt_valid !== 1'b0 || sel !== 3'd0 || gnt_onehot !== 8'h00) begin
      errors++;
      $display("FAIL reset: valid=%b sel=%0d onehot=%h, want 0/0/00", gnt_valid, sel, gnt_onehot);
    end
    rst = 0; gnt_ready = 0;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || sel !== 3'd0 || gnt_onehot !== 8'h01) begin
      errors++;
      $display("FAIL first_grant: valid=%b sel=%0d onehot=%h, want 1/0/01", gnt_valid, sel, gnt_onehot);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_sel;
    gnt_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      exp_sel = 3'(i);
      step();
      checks++;
      if (gnt_valid !== 1'b1 || sel !== exp_sel || din[sel] !== din[exp_sel] || gnt_onehot !== (8'h01 << exp_sel)) begin
        errors++;
        $display("FAIL rotation[%0d]: valid=%b sel=%0d mux=%h, want 1/%0d/%h", i, gnt_valid, sel, din[sel], exp_sel, din[exp_sel]);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    logic [2:0] exp [3];
    exp[0] = 3'd0; exp[1] = 3'd5; exp[2] = 3'd0;
    do_reset();
    req = 8'h20;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || sel !== 3'd5) begin
      errors++;
      $display("FAIL sparse_setup: valid=%b sel=%0d, want 1/5", gnt_valid, sel);
    end
    req = 8'b0010_0001; gnt_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt_valid !== 1'b1 || sel !== exp[i]) begin
        errors++;
        $display("FAIL sparse[%0d]: valid=%b sel=%0d, want 1/%0d", i, gnt_valid, sel, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req = 8'h08;
    step();
    req = 8'h00; gnt_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (gnt_valid !== 1'b1 || sel !== 3'd3 || gnt_onehot !== 8'h08) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b sel=%0d onehot=%h, want 1/3/08", i, gnt_valid, sel, gnt_onehot);
      end
    end
    gnt_ready = 1;
    step();
    checks++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00 || sel !== 3'd3) begin
      errors++;
      $display("FAIL stall_release: valid=%b sel=%0d onehot=%h, want 0/3/00", gnt_valid, sel, gnt_onehot);
    end
    step();
    checks++;
    if (gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: valid=%b, want 0", gnt_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h10; gnt_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (gnt_valid !== 1'b1 || sel !== 3'd4 || gnt_onehot !== 8'h10) begin
        errors++;
        $display("FAIL single[%0d]: valid=%b sel=%0d onehot=%h, want 1/4/10", i, gnt_valid, sel, gnt_onehot);
      end
    end
  endtask

  task automatic test_mid_reset();
    req = 8'hFF; gnt_ready = 0; rst = 1;
    step();
    checks++;
    if (gnt_valid !== 1'b0 || sel !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b sel=%0d, want 0/0", gnt_valid, sel);
    end
    rst = 0;
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 8'h04;
    step();
    req = 8'hFF; gnt_ready = 1; lock = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt_valid !== 1'b1 || sel !== 3'd2) begin
        errors++;
        $display("FAIL lock[%0d]: valid=%b sel=%0d, want 1/2", i, gnt_valid, sel);
      end
    end
    lock = 0;
    step();
    checks++;
    if (gnt_valid !== 1'b1 || sel !== 3'd3) begin
      errors++;
      $display("FAIL unlock: valid=%b sel=%0d, want 1/3", gnt_valid, sel);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) din[i] = 8'hA0 + 8'(i);
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_stall();
    test_single();
    test_mid_reset();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
